// File: rtl/wb_uart_rx_pkg.sv
`default_nettype none
// =====================================================================
// Module   : wb_uart_rx_pkg
// Brief    : Shared types and constants for the UART receive deframer
// Revision : 1.0
// =====================================================================
package wb_uart_rx_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    BRKWAIT = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_char_t;

endpackage
`default_nettype wire

// File: rtl/wb_uart_rx_fifo.sv
`default_nettype none
// =====================================================================
// Module   : wb_uart_rx_fifo
// Brief    : First-word-fall-through character FIFO with overrun pulse
// Revision : 1.0
// =====================================================================
module wb_uart_rx_fifo
  import wb_uart_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  rx_char_t                 i_data,
  input  logic                     i_pop,
  output rx_char_t                 o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overrun
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL    = DEPTH[c_AW:0];
  localparam logic [c_AW:0]   c_LVL_ONE = {{c_AW{1'b0}}, 1'b1};
  localparam logic [c_AW-1:0] c_PTR_ONE = {{(c_AW-1){1'b0}}, 1'b1};

  rx_char_t        r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_level;
  logic            r_overrun;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_full  = (r_level == c_FULL);
  assign o_empty = (r_level == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts
  assign w_wr    = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_push & w_full & ~w_pop;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/wb_uart_rx_deframer.sv
`default_nettype none
// =====================================================================
// Module   : wb_uart_rx_deframer
// Brief    : 16x oversampled async serial receiver feeding a byte FIFO
// Revision : 1.0
// =====================================================================
module wb_uart_rx_deframer
  import wb_uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [DIV_W-1:0]              divisor_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          rx_i,
  output logic [7:0]                    dat_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overrun_o,
  output logic                          break_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam logic [2:0] c_ST_IDLE    = IDLE;
  localparam logic [2:0] c_ST_START   = START;
  localparam logic [2:0] c_ST_DATA    = DATA;
  localparam logic [2:0] c_ST_PARITY  = PARITY;
  localparam logic [2:0] c_ST_STOP    = STOP;
  localparam logic [2:0] c_ST_BRKWAIT = BRKWAIT;

  localparam logic [3:0]       c_SC_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       c_SC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]       c_SC_ONE  = 4'd1;
  localparam logic [DIV_W-1:0] c_DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_d;
  logic [DIV_W-1:0] r_div_m1;
  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_state;
  logic [3:0]       r_sc;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_pe;
  logic             r_break;

  logic             w_rx_s;
  logic             w_fall;
  logic             w_tick;
  logic [DIV_W-1:0] w_div_m1;
  logic             w_bit_end;
  logic             w_push;
  rx_char_t         w_push_char;
  rx_char_t         w_head;
  logic             w_empty;
  logic             w_pop;

  assign w_rx_s   = r_sync2;
  assign w_fall   = r_rx_d & ~r_sync2;
  assign w_tick   = (r_div_cnt == '0);
  assign w_div_m1 = (divisor_i == '0) ? '0 : divisor_i - c_DIV_ONE;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Divisor is captured at start detect so a mid-frame change cannot skew sampling
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_div_m1  <= '0;
      r_div_cnt <= '0;
    end else if (r_state == c_ST_IDLE) begin
      if (w_fall) begin
        r_div_m1  <= w_div_m1;
        r_div_cnt <= w_div_m1;
      end else begin
        r_div_cnt <= r_div_m1;
      end
    end else if (w_tick) begin
      r_div_cnt <= r_div_m1;
    end else begin
      r_div_cnt <= r_div_cnt - c_DIV_ONE;
    end
  end

  // After mid-start, every 16th tick lands in the middle of the next bit
  assign w_bit_end = w_tick && (r_sc == c_SC_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= c_ST_IDLE;
      r_sc    <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_pe    <= 1'b0;
      r_break <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_fall) begin
            r_state <= c_ST_START;
            r_sc    <= '0;
            r_pe    <= 1'b0;
          end
        end
        c_ST_START: begin
          if (w_tick) begin
            if (r_sc == c_SC_MID) begin
              r_sc    <= '0;
              r_bit   <= '0;
              r_state <= w_rx_s ? c_ST_IDLE : c_ST_DATA;
            end else begin
              r_sc <= r_sc + c_SC_ONE;
            end
          end
        end
        c_ST_DATA: begin
          if (w_tick) begin
            r_sc <= r_sc + c_SC_ONE;
          end
          if (w_bit_end) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= parity_en_i ? c_ST_PARITY : c_ST_STOP;
            end
          end
        end
        c_ST_PARITY: begin
          if (w_tick) begin
            r_sc <= r_sc + c_SC_ONE;
          end
          if (w_bit_end) begin
            r_pe    <= w_rx_s ^ (^r_shift) ^ parity_odd_i;
            r_state <= c_ST_STOP;
          end
        end
        c_ST_STOP: begin
          if (w_tick) begin
            r_sc <= r_sc + c_SC_ONE;
          end
          if (w_bit_end) begin
            if (w_rx_s) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_state <= c_ST_BRKWAIT;
              r_break <= (r_shift == 8'h00);
            end
          end
        end
        c_ST_BRKWAIT: begin
          if (w_rx_s) begin
            r_break <= 1'b0;
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // An all-zero character with a low stop bit is a break and is never queued
  assign w_push           = (r_state == c_ST_STOP) && w_bit_end && (w_rx_s || (r_shift != 8'h00));
  assign w_push_char.fe   = ~w_rx_s;
  assign w_push_char.pe   = r_pe;
  assign w_push_char.data = r_shift;
  assign w_pop            = valid_o & ready_i;

  wb_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .i_push    (w_push),
    .i_data    (w_push_char),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_empty   (w_empty),
    .o_level   (level_o),
    .o_overrun (overrun_o)
  );

  assign valid_o      = ~w_empty;
  assign dat_o        = valid_o ? w_head.data : 8'h00;
  assign frame_err_o  = valid_o & w_head.fe;
  assign parity_err_o = valid_o & w_head.pe;
  assign break_o      = r_break;
  assign busy_o       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_rx_deframer.sv
`default_nettype none
// =====================================================================
// Module   : tb_wb_uart_rx_deframer
// Brief    : Table, corner-case and randomized checks of the deframer
// Revision : 1.0
// =====================================================================
module tb_wb_uart_rx_deframer;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic [15:0] divisor_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic        rx_i;
  logic        ready_i;
  logic [7:0]  dat_o;
  logic        frame_err_o;
  logic        parity_err_o;
  logic        valid_o;
  logic        overrun_o;
  logic        break_o;
  logic        busy_o;
  logic [4:0]  level_o;

  wb_uart_rx_deframer #(
    .FIFO_DEPTH (16),
    .DIV_W      (16)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .divisor_i    (divisor_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .rx_i         (rx_i),
    .dat_o        (dat_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .overrun_o    (overrun_o),
    .break_o      (break_o),
    .busy_o       (busy_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t       tv [10];
  int         n_vec = 0;
  int         n_bad = 0;
  int         ovr_cnt = 0;
  int         ovr_base;
  int         lat;
  logic [9:0] q [$];
  logic [9:0] e;
  logic [7:0] rd;
  int         rdiv;
  logic       rpen, rpodd, rpbit, rstop;

  always @(negedge clk) begin
    if (rstn_i && overrun_o) ovr_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int div, input logic scramble);
    int bp;
    bp = 16 * ((div == 0) ? 1 : div);
    divisor_i = 16'(div);
    drive(1'b0, bp);
    if (scramble) divisor_i = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 8; i++) drive(d[i], bp);
    if (pen) drive(pbit, bp);
    drive(stop, bp);
    divisor_i = 16'(div);
    drive(1'b1, 2 * bp);
  endtask

  task automatic pop_check(input string nm, input logic [7:0] ed, input logic efe, input logic epe);
    check({nm, " valid"}, 32'(valid_o), 32'd1);
    check({nm, " data"}, 32'(dat_o), 32'(ed));
    check({nm, " fe"}, 32'(frame_err_o), 32'(efe));
    check({nm, " pe"}, 32'(parity_err_o), 32'(epe));
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            data   div pen   podd  pbit  stop  valid fe    pe
    tv[0] = '{8'hA3, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[1] = '{8'hA3, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[2] = '{8'hA3, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[3] = '{8'h07, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[4] = '{8'h07, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[5] = '{8'h3C, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[6] = '{8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7] = '{8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[8] = '{8'hFF, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[9] = '{8'h81, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rstn_i = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    divisor_i = 16'd1; parity_en_i = 1'b0; parity_odd_i = 1'b0;
    #3 rstn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", 32'(valid_o), 0);
    check("reset data", 32'(dat_o), 0);
    check("reset fe", 32'(frame_err_o), 0);
    check("reset pe", 32'(parity_err_o), 0);
    check("reset overrun", 32'(overrun_o), 0);
    check("reset break", 32'(break_o), 0);
    check("reset busy", 32'(busy_o), 0);
    check("reset level", 32'(level_o), 0);
    rstn_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 0x55 8N1 at divisor 1: valid_o must rise 155 cycles after the start edge
    lat = -1;
    fork
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(posedge clk);
          #1;
          if (valid_o) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("latency 0x55", 32'(lat), 32'd155);
    pop_check("first 0x55", 8'h55, 1'b0, 1'b0);
    check("after pop valid", 32'(valid_o), 0);

    for (int i = 0; i < 10; i++) begin
      parity_en_i  = tv[i].pen;
      parity_odd_i = tv[i].podd;
      send_frame(tv[i].data, tv[i].pen, tv[i].pbit, tv[i].stop, tv[i].div, 1'b0);
      check($sformatf("tv%0d valid", i), 32'(valid_o), 32'(tv[i].exp_valid));
      check($sformatf("tv%0d break", i), 32'(break_o), 0);
      if (tv[i].exp_valid) pop_check($sformatf("tv%0d", i), tv[i].data, tv[i].exp_fe, tv[i].exp_pe);
    end
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;

    // Line held low for two frame times is a break, never a character
    divisor_i = 16'd1;
    drive(1'b0, 320);
    check("break held", 32'(break_o), 1);
    check("break busy", 32'(busy_o), 1);
    check("break no push", 32'(valid_o), 0);
    drive(1'b1, 5);
    check("break released", 32'(break_o), 0);
    check("break idle", 32'(busy_o), 0);
    check("break still empty", 32'(valid_o), 0);

    // Fill to 16, then a 17th character overruns
    ovr_base = ovr_cnt;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1, 1'b0);
    check("fill level", 32'(level_o), 16);
    check("overrun pulses", 32'(ovr_cnt - ovr_base), 1);
    check("full head", 32'(dat_o), 0);

    // Full FIFO with a pop in the push cycle: both happen, no overrun
    ovr_base = ovr_cnt;
    fork
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      begin
        repeat (154) @(posedge clk);
        #1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
      end
    join
    check("full push+pop level", 32'(level_o), 16);
    check("full push+pop overrun", 32'(ovr_cnt - ovr_base), 0);
    for (int i = 1; i < 16; i++) pop_check($sformatf("drain %0d", i), 8'(i), 1'b0, 1'b0);
    pop_check("drain tail", 8'h5A, 1'b0, 1'b0);
    check("drained", 32'(valid_o), 0);

    // Short low glitch aborts at the mid-start sample
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_i = 1'b1;
    check("glitch busy", 32'(busy_o), 1);
    repeat (16) @(posedge clk);
    #1;
    check("glitch idle", 32'(busy_o), 0);
    check("glitch no push", 32'(valid_o), 0);

    // Reset in the middle of 0x7E, held until the line is idle again
    fork
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      begin
        repeat (60) @(posedge clk);
        #2;
        check("pre-reset busy", 32'(busy_o), 1);
        rstn_i = 1'b0;
        #1;
        check("mid reset busy", 32'(busy_o), 0);
        check("mid reset valid", 32'(valid_o), 0);
        check("mid reset level", 32'(level_o), 0);
        check("mid reset data", 32'(dat_o), 0);
      end
    join
    rstn_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post reset empty", 32'(valid_o), 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    pop_check("post reset 0x81", 8'h81, 1'b0, 1'b0);

    // Random frames against a queue model of the character rules
    for (int f = 0; f < 24; f++) begin
      rd    = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rd = 8'h00;
      rdiv  = $urandom_range(0, 3);
      rpen  = 1'($urandom);
      rpodd = 1'($urandom);
      rpbit = 1'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      parity_en_i  = rpen;
      parity_odd_i = rpodd;
      send_frame(rd, rpen, rpbit, rstop, rdiv, 1'b1);
      if (rstop || rd != 8'h00) begin
        if (q.size() < 16) q.push_back({~rstop, rpen && (rpbit != ((^rd) ^ rpodd)), rd});
      end
      check($sformatf("rand%0d level", f), 32'(level_o), 32'(q.size()));
      if ($urandom_range(0, 2) != 0 && q.size() > 0) begin
        e = q.pop_front();
        pop_check($sformatf("rand%0d", f), e[7:0], e[9], e[8]);
      end
    end
    for (int i = 0; i < 16 && q.size() > 0; i++) begin
      e = q.pop_front();
      pop_check($sformatf("rand drain %0d", i), e[7:0], e[9], e[8]);
    end
    check("rand final empty", 32'(valid_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
